// File: rtl/core_pkg.sv
// Shared core definitions: default datapath widths, ALU operation encodings
// and the hard-wired zero register.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ALUCTL_W = 3;
    localparam int F3_W     = 3;
    localparam int CNT_W    = 16;

    typedef enum logic [ALUCTL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    // Rename check: a real producer writes a non-zero destination that matches a source.
    function automatic logic reg_match(input logic [REG_AW-1:0] dst,
                                       input logic [REG_AW-1:0] src);
        return (dst != ZERO_REG) && (dst == src);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between a load in a later stage and the
// instruction currently being decoded. Register x0 never creates a hazard.
module load_use_detect #(
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic              valid_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic [REG_AW-1:0] a3_e,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rd1_addr_d,
    input  logic [REG_AW-1:0] rd2_addr_d,
    output logic              hazard
);
    import core_pkg::*;

    logic is_load_s;
    logic dst_live_s;
    logic src_hit_s;

    assign is_load_s  = valid_e & reg_write_e & mem_to_reg_e;
    assign dst_live_s = (a3_e != REG_AW'(ZERO_REG));
    assign src_hit_s  = (a3_e == rd1_addr_d) | (a3_e == rd2_addr_d);
    assign hazard     = is_load_s & dst_live_s & valid_d & src_hit_s;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush/stall priority, load-use bubble insertion
// and a saturating bubble counter.
module id_ex_pipe #(
    parameter int XLEN     = core_pkg::XLEN,
    parameter int REG_AW   = core_pkg::REG_AW,
    parameter int ALUCTL_W = core_pkg::ALUCTL_W,
    parameter int F3_W     = core_pkg::F3_W,
    parameter int CNT_W    = core_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ValidD,
    input  logic [XLEN-1:0]     RD1D,
    input  logic [XLEN-1:0]     RD2D,
    input  logic [XLEN-1:0]     SignImmD,
    input  logic [REG_AW-1:0]   RD1AddrD,
    input  logic [REG_AW-1:0]   RD2AddrD,
    input  logic [REG_AW-1:0]   A3D,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                ALUSrcD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [F3_W-1:0]     funct3D,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic                CntClr,
    output logic                ValidE,
    output logic [XLEN-1:0]     RD1E,
    output logic [XLEN-1:0]     RD2E,
    output logic [XLEN-1:0]     SignImmE,
    output logic [REG_AW-1:0]   RD1AddrE,
    output logic [REG_AW-1:0]   RD2AddrE,
    output logic [REG_AW-1:0]   A3E,
    output logic                RegWriteE,
    output logic                MemtoRegE,
    output logic                MemWriteE,
    output logic                ALUSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic [F3_W-1:0]     funct3E,
    output logic                LoadUseStallD,
    output logic [CNT_W-1:0]    BubbleCnt
);

    logic                valid_r,      valid_s;
    logic [XLEN-1:0]     rd1_r,        rd1_s;
    logic [XLEN-1:0]     rd2_r,        rd2_s;
    logic [XLEN-1:0]     imm_r,        imm_s;
    logic [REG_AW-1:0]   rd1_addr_r,   rd1_addr_s;
    logic [REG_AW-1:0]   rd2_addr_r,   rd2_addr_s;
    logic [REG_AW-1:0]   a3_r,         a3_s;
    logic                reg_write_r,  reg_write_s;
    logic                mem_to_reg_r, mem_to_reg_s;
    logic                mem_write_r,  mem_write_s;
    logic                alu_src_r,    alu_src_s;
    logic [ALUCTL_W-1:0] alu_ctl_r,    alu_ctl_s;
    logic [F3_W-1:0]     funct3_r,     funct3_s;
    logic [CNT_W-1:0]    cnt_r,        cnt_s;
    logic                hazard_s;
    logic                bubble_s;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .valid_e      (valid_r),
        .reg_write_e  (reg_write_r),
        .mem_to_reg_e (mem_to_reg_r),
        .a3_e         (a3_r),
        .valid_d      (ValidD),
        .rd1_addr_d   (RD1AddrD),
        .rd2_addr_d   (RD2AddrD),
        .hazard       (hazard_s)
    );

    // Next E-stage contents: flush > stall > bubble > capture.
    always_comb begin
        valid_s      = valid_r;
        rd1_s        = rd1_r;
        rd2_s        = rd2_r;
        imm_s        = imm_r;
        rd1_addr_s   = rd1_addr_r;
        rd2_addr_s   = rd2_addr_r;
        a3_s         = a3_r;
        reg_write_s  = reg_write_r;
        mem_to_reg_s = mem_to_reg_r;
        mem_write_s  = mem_write_r;
        alu_src_s    = alu_src_r;
        alu_ctl_s    = alu_ctl_r;
        funct3_s     = funct3_r;
        bubble_s     = 1'b0;
        if (FlushE || (!StallE && hazard_s)) begin
            // Kill keeps data fields; only validity and controls are cleared.
            valid_s      = 1'b0;
            reg_write_s  = 1'b0;
            mem_to_reg_s = 1'b0;
            mem_write_s  = 1'b0;
            alu_src_s    = 1'b0;
            alu_ctl_s    = {ALUCTL_W{1'b0}};
            bubble_s     = !FlushE;
        end else if (StallE) begin
            valid_s      = valid_r;
        end else begin
            valid_s      = ValidD;
            rd1_s        = RD1D;
            rd2_s        = RD2D;
            imm_s        = SignImmD;
            rd1_addr_s   = RD1AddrD;
            rd2_addr_s   = RD2AddrD;
            a3_s         = A3D;
            funct3_s     = funct3D;
            // Empty decode slot never carries live controls into E.
            reg_write_s  = ValidD & RegWriteD;
            mem_to_reg_s = ValidD & MemtoRegD;
            mem_write_s  = ValidD & MemWriteD;
            alu_src_s    = ValidD & ALUSrcD;
            alu_ctl_s    = ValidD ? ALUControlD : {ALUCTL_W{1'b0}};
        end
    end

    // Bubble counter: clear wins, otherwise saturating increment on a bubble.
    always_comb begin
        cnt_s = cnt_r;
        if (CntClr) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (bubble_s && !(&cnt_r)) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // E-stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= 1'b0;
            rd1_r        <= {XLEN{1'b0}};
            rd2_r        <= {XLEN{1'b0}};
            imm_r        <= {XLEN{1'b0}};
            rd1_addr_r   <= {REG_AW{1'b0}};
            rd2_addr_r   <= {REG_AW{1'b0}};
            a3_r         <= {REG_AW{1'b0}};
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            mem_write_r  <= 1'b0;
            alu_src_r    <= 1'b0;
            alu_ctl_r    <= {ALUCTL_W{1'b0}};
            funct3_r     <= {F3_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            valid_r      <= valid_s;
            rd1_r        <= rd1_s;
            rd2_r        <= rd2_s;
            imm_r        <= imm_s;
            rd1_addr_r   <= rd1_addr_s;
            rd2_addr_r   <= rd2_addr_s;
            a3_r         <= a3_s;
            reg_write_r  <= reg_write_s;
            mem_to_reg_r <= mem_to_reg_s;
            mem_write_r  <= mem_write_s;
            alu_src_r    <= alu_src_s;
            alu_ctl_r    <= alu_ctl_s;
            funct3_r     <= funct3_s;
            cnt_r        <= cnt_s;
        end
    end

    assign ValidE        = valid_r;
    assign RD1E          = rd1_r;
    assign RD2E          = rd2_r;
    assign SignImmE      = imm_r;
    assign RD1AddrE      = rd1_addr_r;
    assign RD2AddrE      = rd2_addr_r;
    assign A3E           = a3_r;
    assign RegWriteE     = reg_write_r;
    assign MemtoRegE     = mem_to_reg_r;
    assign MemWriteE     = mem_write_r;
    assign ALUSrcE       = alu_src_r;
    assign ALUControlE   = alu_ctl_r;
    assign funct3E       = funct3_r;
    assign LoadUseStallD = hazard_s;
    assign BubbleCnt     = cnt_r;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table, reset/saturation sequences and
// randomized traffic against a behavioural model of the E stage.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidD;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RD1AddrD, RD2AddrD, A3D;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD;
    logic [2:0]  ALUControlD, funct3D;
    logic        StallE, FlushE, CntClr;
    logic        ValidE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RD1AddrE, RD2AddrE, A3E;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
    logic [2:0]  ALUControlE, funct3E;
    logic        LoadUseStallD;
    logic [1:0]  BubbleCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.XLEN(32), .REG_AW(5), .ALUCTL_W(3), .F3_W(3), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D),
        .SignImmD(SignImmD), .RD1AddrD(RD1AddrD), .RD2AddrD(RD2AddrD), .A3D(A3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .funct3D(funct3D),
        .StallE(StallE), .FlushE(FlushE), .CntClr(CntClr), .ValidE(ValidE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RD1AddrE(RD1AddrE),
        .RD2AddrE(RD2AddrE), .A3E(A3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .funct3E(funct3E), .LoadUseStallD(LoadUseStallD), .BubbleCnt(BubbleCnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of what E should hold ----------------
    typedef struct {
        logic        valid, rw, m2r, mw, as;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  a1, a2, a3;
        logic [2:0]  ac, f3;
    } stage_t;

    stage_t m;
    int     mcnt;

    function automatic void model_reset();
        m = '{valid: 1'b0, rw: 1'b0, m2r: 1'b0, mw: 1'b0, as: 1'b0,
              rd1: 32'd0, rd2: 32'd0, imm: 32'd0, a1: 5'd0, a2: 5'd0, a3: 5'd0,
              ac: 3'd0, f3: 3'd0};
        mcnt = 0;
    endfunction

    // A load in E whose non-zero destination feeds the live decode instruction.
    function automatic logic model_hazard();
        return m.valid && m.rw && m.m2r && (m.a3 != 5'd0) && ValidD
               && ((m.a3 == RD1AddrD) || (m.a3 == RD2AddrD));
    endfunction

    function automatic void kill_e();
        m.valid = 1'b0; m.rw = 1'b0; m.m2r = 1'b0; m.mw = 1'b0; m.as = 1'b0; m.ac = 3'd0;
    endfunction

    function automatic void model_step(input logic hz);
        if (FlushE) begin
            kill_e();
        end else if (StallE) begin
            m.valid = m.valid;
        end else if (hz) begin
            kill_e();
            if (mcnt < 3) mcnt = mcnt + 1;
        end else begin
            m.valid = ValidD;
            m.rd1 = RD1D; m.rd2 = RD2D; m.imm = SignImmD;
            m.a1 = RD1AddrD; m.a2 = RD2AddrD; m.a3 = A3D; m.f3 = funct3D;
            m.rw  = ValidD && RegWriteD;
            m.m2r = ValidD && MemtoRegD;
            m.mw  = ValidD && MemWriteD;
            m.as  = ValidD && ALUSrcD;
            m.ac  = ValidD ? ALUControlD : 3'd0;
        end
        if (CntClr) mcnt = 0;
    endfunction

    task automatic check_e(input string tag);
        chk({tag, ".ValidE"},    {31'd0, ValidE},    {31'd0, m.valid});
        chk({tag, ".RD1E"},      RD1E,               m.rd1);
        chk({tag, ".RD2E"},      RD2E,               m.rd2);
        chk({tag, ".SignImmE"},  SignImmE,           m.imm);
        chk({tag, ".RD1AddrE"},  {27'd0, RD1AddrE},  {27'd0, m.a1});
        chk({tag, ".RD2AddrE"},  {27'd0, RD2AddrE},  {27'd0, m.a2});
        chk({tag, ".A3E"},       {27'd0, A3E},       {27'd0, m.a3});
        chk({tag, ".ctrl"},      {27'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, 1'b0},
                                 {27'd0, m.rw, m.m2r, m.mw, m.as, 1'b0});
        chk({tag, ".ALUCtlE"},   {29'd0, ALUControlE}, {29'd0, m.ac});
        chk({tag, ".funct3E"},   {29'd0, funct3E},   {29'd0, m.f3});
        chk({tag, ".BubbleCnt"}, {30'd0, BubbleCnt}, mcnt);
        chk({tag, ".invariant"}, {31'd0, !(RegWriteE || MemWriteE || MemtoRegE) || ValidE}, 32'd1);
    endtask

    // One clock against the model: combinational stall before the edge, E after it.
    task automatic model_cycle(input string tag);
        logic hz;
        hz = model_hazard();
        #1;
        chk({tag, ".LoadUseStallD"}, {31'd0, LoadUseStallD}, {31'd0, hz});
        @(posedge clk);
        model_step(hz);
        #1;
        check_e(tag);
    endtask

    task automatic drive(input logic vd, input logic [31:0] rd1, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3, input logic rw,
                         input logic m2r, input logic mw, input logic st, input logic fl,
                         input logic clr);
        ValidD = vd; RD1D = rd1; RD2D = ~rd1; SignImmD = rd1 ^ 32'h0F0F_0F0F;
        RD1AddrD = a1; RD2AddrD = a2; A3D = a3;
        RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; ALUSrcD = rd1[0];
        ALUControlD = rd1[2:0]; funct3D = rd1[5:3];
        StallE = st; FlushE = fl; CntClr = clr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        vd; logic [31:0] rd1; logic [4:0] a1, a2, a3;
        logic        rw, m2r, mw, st, fl, clr;
        logic        e_lus, e_ve, e_rw, e_mw; logic [4:0] e_a3; logic [31:0] e_rd1; logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        //          vd rd1            a1    a2    a3    rw   m2r  mw   st   fl   clr  lus  ve   rw   mw   a3    rd1            cnt
        tbl[0]  = '{1'b1, 32'h1234_5678, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234_5678, 2'd0};
        tbl[1]  = '{1'b1, 32'hAAAA_0001, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hAAAA_0001, 2'd0};
        tbl[2]  = '{1'b1, 32'hBBBB_0002, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hAAAA_0001, 2'd1};
        tbl[3]  = '{1'b1, 32'hBBBB_0002, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'hBBBB_0002, 2'd1};
        tbl[4]  = '{1'b1, 32'h0000_00C0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_00C0, 2'd1};
        tbl[5]  = '{1'b1, 32'h0000_00D0, 5'd0, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_00D0, 2'd1};
        tbl[6]  = '{1'b1, 32'h0000_00E0, 5'd5, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_00D0, 2'd1};
        tbl[7]  = '{1'b1, 32'h0000_00E1, 5'd5, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_00D0, 2'd1};
        tbl[8]  = '{1'b1, 32'h0000_00E2, 5'd5, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_00D0, 2'd1};
        tbl[9]  = '{1'b1, 32'h0000_00F0, 5'd5, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_00F0, 2'd1};
        tbl[10] = '{1'b0, 32'h0000_0011, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0011, 2'd1};
        tbl[11] = '{1'b1, 32'h0000_0022, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0022, 2'd0};
        tbl[12] = '{1'b1, 32'h0000_0033, 5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h0000_0022, 2'd0};
        tbl[13] = '{1'b1, 32'h0000_0044, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_0044, 2'd0};
        tbl[14] = '{1'b1, 32'h0000_0055, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'h0000_0055, 2'd0};

        rst_n = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_e("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vd, tbl[i].rd1, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].rw,
                  tbl[i].m2r, tbl[i].mw, tbl[i].st, tbl[i].fl, tbl[i].clr);
            #1;
            chk($sformatf("vec%0d.LoadUseStallD", i), {31'd0, LoadUseStallD}, {31'd0, tbl[i].e_lus});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.ValidE", i),    {31'd0, ValidE},    {31'd0, tbl[i].e_ve});
            chk($sformatf("vec%0d.RegWriteE", i), {31'd0, RegWriteE}, {31'd0, tbl[i].e_rw});
            chk($sformatf("vec%0d.MemWriteE", i), {31'd0, MemWriteE}, {31'd0, tbl[i].e_mw});
            chk($sformatf("vec%0d.A3E", i),       {27'd0, A3E},       {27'd0, tbl[i].e_a3});
            chk($sformatf("vec%0d.RD1E", i),      RD1E,               tbl[i].e_rd1);
            chk($sformatf("vec%0d.BubbleCnt", i), {30'd0, BubbleCnt}, {30'd0, tbl[i].e_cnt});
        end

        // Mid-stream asynchronous reset with a live load in E.
        drive(1'b1, 32'h0BAD_F00D, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("prerst.ValidE", {31'd0, ValidE}, 32'd1);
        drive(1'b1, 32'h0000_0066, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("prerst.LoadUseStallD", {31'd0, LoadUseStallD}, 32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_e("asyncrst");
        chk("asyncrst.LoadUseStallD", {31'd0, LoadUseStallD}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_cycle("postrst");
        chk("postrst.capture", RD1E, 32'h0000_0066);

        // Saturation: five load-use bubbles on a 2-bit counter.
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_cycle("satclr");
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h100 + k, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            model_cycle("satload");
            drive(1'b1, 32'h200 + k, 5'd6, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            model_cycle("satuse");
        end
        chk("sat.BubbleCnt", {30'd0, BubbleCnt}, 32'd3);
        drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_cycle("clrload");
        drive(1'b1, 32'h301, 5'd0, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_cycle("clrhaz");
        chk("clrhaz.BubbleCnt", {30'd0, BubbleCnt}, 32'd0);

        // Randomized traffic with a narrow register range to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 9) != 0), $urandom(),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom()), 1'($urandom()), 1'($urandom()),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 29) == 0));
            ALUControlD = 3'($urandom());
            funct3D     = 3'($urandom());
            ALUSrcD     = 1'($urandom());
            model_cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register for the five-stage core, with stall, flush, a per-stage valid bit and built-in load-use hazard detection. It sits between decode and execute and captures register operands, sign-extended immediate, source and destination register addresses, funct3 and the control bundle. It inserts bubbles on load-use hazards, holds on downstream stalls and clears on branch flushes. A saturating counter records the number of inserted load-use bubbles for performance analysis.

## Interface
Parameters:
- XLEN, 32, operand and immediate width
- REG_AW, 5, register-address width
- ALUCTL_W, 3, ALU control width
- F3_W, 3, funct3 width
- CNT_W, 16, bubble-counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D  in  XLEN  register-file read data
- SignImmD  in  XLEN  sign-extended immediate
- RD1AddrD, RD2AddrD  in  REG_AW  source register addresses
- A3D  in  REG_AW  destination register address
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD  in  1 each  control bits
- ALUControlD  in  ALUCTL_W  ALU operation
- funct3D  in  F3_W  funct3 field
- StallE  in  1  downstream stall: hold all E outputs
- FlushE  in  1  branch or redirect: kill the instruction entering E
- CntClr  in  1  synchronous clear of BubbleCnt
- ValidE, RD1E, RD2E, SignImmE, RD1AddrE, RD2AddrE, A3E, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE, funct3E  out  widths as the D counterparts  registered E-stage copies
- LoadUseStallD  out  1  combinational request to freeze PC and IF/ID
- BubbleCnt  out  CNT_W  saturating count of load-use bubbles

## Operation
Hazard detection:
- hazard = ValidE & RegWriteE & MemtoRegE & (A3E != 0) & ValidD & ((A3E == RD1AddrD) | (A3E == RD2AddrD)).
- LoadUseStallD = hazard. It is not gated by StallE, because upstream freezes on StallE | LoadUseStallD.

Per-edge update priority (highest first):
1. FlushE: ValidE and all control outputs (RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE) become 0. Data, address and funct3 fields hold.
2. StallE: every output holds.
3. hazard: a bubble is inserted, with the same clearing as flush. BubbleCnt increments.
4. Otherwise: capture all D inputs. If ValidD = 0, control outputs are captured as 0 and ValidE = 0.

Invariants and counter:
- Invariant: (RegWriteE | MemWriteE | MemtoRegE) implies ValidE.
- BubbleCnt increments only for case 3. Flushes do not count.
- BubbleCnt saturates at 2^CNT_W - 1.
- CntClr forces BubbleCnt to 0 and overrides an increment in the same cycle.
- Register x0 never triggers a hazard.

## Timing
- Latency: 1 cycle from D input to E output.
- LoadUseStallD is combinational from the D inputs and the E registers. It is valid the same cycle; there is no registered path.
- Load-use response: with a load in E and a dependent instruction in D, LoadUseStallD = 1 for exactly one cycle.
  - On the next edge, E holds a bubble and the dependent instruction is still in D, because upstream froze.
  - The following edge captures the dependent instruction.
- FlushE together with StallE in the same cycle: flush wins and E is cleared.
- FlushE together with a hazard: flush wins and the counter does not increment.
- Reset, asynchronous on rst_n falling:
  - every output register and BubbleCnt go to 0 immediately, so ValidE = 0 and all controls = 0;
  - LoadUseStallD goes to 0 because ValidE = 0.
- Reset mid-operation drops the in-flight E instruction. The first edge after rst_n rises performs a normal capture.

## Structure
- Shared package `core_pkg` holds:
  - default widths XLEN, REG_AW, ALUCTL_W, F3_W;
  - ALU control encodings;
  - the zero-register constant.
- Sub-module `load_use_detect` is purely combinational. It takes ValidE, RegWriteE, MemtoRegE, A3E, ValidD, RD1AddrD and RD2AddrD, and produces hazard. It is reused later for the MEM-stage hazard check.
- The top level holds the registers, the priority logic and the counter.

## Test plan
- Reset: assert rst_n = 0 mid-stream with ValidE = 1 and RegWriteE = 1 -> all outputs 0 immediately, BubbleCnt = 0.
- Pass-through: ValidD = 1, RD1D = 0x1234_5678, A3D = 7, RegWriteD = 1, no stall or flush -> one edge later RD1E = 0x1234_5678, A3E = 7, RegWriteE = 1, ValidE = 1.
- Load-use: load x5 in E (MemtoRegE = 1, RegWriteE = 1, A3E = 5), then RD2AddrD = 5 with ValidD = 1:
  - LoadUseStallD = 1 that cycle;
  - next edge: ValidE = 0, RegWriteE = 0, BubbleCnt = 1;
  - following edge: RD2AddrE = 5, ValidE = 1.
- x0 and non-load:
  - A3E = 0 with MemtoRegE = 1 and RD1AddrD = 0 -> LoadUseStallD = 0;
  - A3E = 5 with MemtoRegE = 0 and RD1AddrD = 5 -> LoadUseStallD = 0.
- Stall and flush priority:
  - StallE = 1 for 3 cycles with changing D inputs -> E outputs constant;
  - FlushE = 1 together with StallE = 1 -> ValidE = 0, MemWriteE = 0, data fields unchanged.
- Counter: CNT_W = 2 with 5 load-use bubbles -> BubbleCnt saturates at 3. CntClr together with a hazard -> BubbleCnt = 0.
